rb_write_scheduler: RTL
=======================

// Module: rb_write_scheduler
// PURPOSE
//  Shares the register bank's single write port between two writeback requesters: A = ALU result, B = memory load.
//  Holds a per-register busy scoreboard so issue logic can stall on pending destinations.
//  Sits between the execute/memory stages and the register bank; drives the bank's EnW/AW/DW inputs from registered outputs.
// PARAMETERS
//  DATA_W  32  register data width
//  ADDR_W  5   register address width
//  NREG    32  number of registers (2**ADDR_W)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  a_valid     in   1       ALU writeback request
//  a_addr      in   ADDR_W  ALU destination register
//  a_data      in   DATA_W  ALU result
//  a_ready     out  1       ALU request accepted this cycle
//  b_valid     in   1       load writeback request
//  b_addr      in   ADDR_W  load destination register
//  b_data      in   DATA_W  load data
//  b_ready     out  1       load request accepted this cycle
//  mark_valid  in   1       issue stage reserves a destination
//  mark_addr   in   ADDR_W  register to mark busy
//  chk_addr1   in   ADDR_W  source operand 1 to check
//  chk_addr2   in   ADDR_W  source operand 2 to check
//  chk_busy1   out  1       busy[chk_addr1], combinational
//  chk_busy2   out  1       busy[chk_addr2], combinational
//  rb_enw      out  1       register bank write enable (EnW)
//  rb_aw       out  ADDR_W  register bank write address (AW)
//  rb_dw       out  DATA_W  register bank write data (DW)
//  wr_count    out  16      committed-write counter, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0): rb_enw=0, rb_aw=0, rb_dw=0, wr_count=0, busy[]=0, prio=A. Applies immediately, including mid-operation; pending grants are dropped.
//  Arbitration (combinational):
//   - One grant per cycle. a_ready = a_valid & (~b_valid | prio==A); b_ready = b_valid & (~a_valid | prio==B).
//   - prio toggles to the loser only when both are valid in the same cycle; otherwise unchanged.
//   - No back-pressure from the bank; the loser holds its valid/addr/data until ready.
//  Issue latency 1:
//   - On the edge where X_valid & X_ready: rb_aw<=X_addr, rb_dw<=X_data, rb_enw<=(X_addr!=0).
//   - With no acceptance: rb_enw<=0; rb_aw/rb_dw hold.
//  Register 0: writes to addr 0 are accepted (ready asserted) but never reach the bank; wr_count is not incremented.
//  wr_count increments on each edge that loads rb_enw=1.
//  Scoreboard:
//   - busy[r] set on the edge where mark_valid & mark_addr==r & r!=0.
//   - busy[r] cleared on the edge where a write to r is accepted.
//   - Same edge set & clear of r: set wins (newer producer).
//   - busy[0] is constant 0; chk_busy reflects the current busy[] state.
//   - A reader sees busy=0 in the cycle rb_enw=1 for that register, which is the cycle the bank writes it.
//  Both requesters with the same addr: the arbitration order defines the final bank value.
// STRUCTURE
//  Shared package rb_pkg: DATA_W/ADDR_W/NREG constants, typedef prio_t {PRIO_A, PRIO_B}.
//  Natural sub-module: rb_scoreboard (busy[] vector, set/clear/check ports). Arbiter and output register stay in this module.
// TESTING
//  1 Reset: rst_n=0 asserted mid-burst -> rb_enw=0, wr_count=0, chk_busy1/2=0 immediately.
//  2 A only: a_valid=1, a_addr=5, a_data=32'h1234 -> a_ready=1; next cycle rb_enw=1, rb_aw=5, rb_dw=32'h1234, wr_count=1.
//  3 Contention: A(addr 3) and B(addr 4) valid for 2 cycles from reset -> A granted first, then B; rb_aw sequence 3,4.
//  4 x0 drop: b_valid=1, b_addr=0, b_data=32'hFFFF_FFFF -> b_ready=1, rb_enw stays 0, wr_count unchanged.
//  5 Scoreboard: mark 7; chk_addr1=7 -> chk_busy1=1; write to 7 accepted -> chk_busy1=0 in the cycle rb_enw=1.
//  6 Set/clear collision: mark_addr=9 on the same edge a write to 9 is accepted -> busy[9]=1 afterwards.

Source files
------------

// File: rtl/rb_pkg.sv
// rb_pkg: shared widths and arbitration priority type for the register-bank write scheduler.
package rb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    typedef enum logic {PRIO_A, PRIO_B} prio_t;
endpackage

// File: rtl/rb_scoreboard.sv
// rb_scoreboard: per-register busy bits; set by issue reservations, cleared by accepted writebacks.
module rb_scoreboard
    import rb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_set_valid,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_valid,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_chk_addr1,
    input  logic [ADDR_W-1:0] i_chk_addr2,
    output logic              o_busy1,
    output logic              o_busy2
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;

    always_comb begin
        w_set = i_set_valid ? (NREG'(1) << i_set_addr) : '0;
        w_clr = i_clr_valid ? (NREG'(1) << i_clr_addr) : '0;
    end

    // set is applied after clear so a new reservation beats a same-edge retirement; x0 never busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREG'(1);
    end

    assign o_busy1 = r_busy[i_chk_addr1];
    assign o_busy2 = r_busy[i_chk_addr2];
endmodule

// File: rtl/rb_write_scheduler.sv
// rb_write_scheduler: round-robin sharing of the register bank write port between ALU (A) and load (B)
// writebacks, with registered bank outputs and a busy scoreboard for issue stalls.
module rb_write_scheduler
    import rb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              chk_busy1,
    output logic              chk_busy2,
    output logic              rb_enw,
    output logic [ADDR_W-1:0] rb_aw,
    output logic [DATA_W-1:0] rb_dw,
    output logic [15:0]       wr_count
);
    prio_t             r_prio;
    logic              r_enw;
    logic [ADDR_W-1:0] r_aw;
    logic [DATA_W-1:0] r_dw;
    logic [15:0]       r_wr_count;
    logic              w_acc;
    logic              w_commit;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    always_comb begin
        a_ready  = a_valid & (~b_valid | (r_prio == PRIO_A));
        b_ready  = b_valid & (~a_valid | (r_prio == PRIO_B));
        w_acc    = a_ready | b_ready;
        w_addr   = a_ready ? a_addr : b_addr;
        w_data   = a_ready ? a_data : b_data;
        w_commit = w_acc & (w_addr != '0);
    end

    // x0 writes are consumed here so the bank never sees them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= PRIO_A;
            r_enw      <= 1'b0;
            r_aw       <= '0;
            r_dw       <= '0;
            r_wr_count <= '0;
        end else begin
            r_enw <= w_commit;
            if (w_acc) begin
                r_aw <= w_addr;
                r_dw <= w_data;
            end
            if (a_valid & b_valid)
                r_prio <= (r_prio == PRIO_A) ? PRIO_B : PRIO_A;
            if (w_commit)
                r_wr_count <= r_wr_count + 16'd1;
        end
    end

    rb_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set_valid (mark_valid),
        .i_set_addr  (mark_addr),
        .i_clr_valid (w_acc),
        .i_clr_addr  (w_addr),
        .i_chk_addr1 (chk_addr1),
        .i_chk_addr2 (chk_addr2),
        .o_busy1     (chk_busy1),
        .o_busy2     (chk_busy2)
    );

    assign rb_enw   = r_enw;
    assign rb_aw    = r_aw;
    assign rb_dw    = r_dw;
    assign wr_count = r_wr_count;
endmodule
